// File: rtl/alu_arbiter_if.sv
// Client request/response handshakes and the ALU operand/result bus of alu_arbiter.
// slave is the arbiter's view; master is the clients-plus-ALU side.
interface alu_arbiter_if #(
  parameter int DATA_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [1:0]        req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        req1_op;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_carry,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_carry,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 4-bit ALU between two clients:
// accept -> one EXEC cycle -> hold the captured result until the owner takes it.
module alu_arbiter #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         busy,
  alu_arbiter_if.slave bus
);
  localparam int   DATA_W   = 4;
  localparam logic PRIO_RST = (PRIO_INIT != 0);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              prio;
  logic              owner;
  logic              grant0, grant1, accept;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] result_p1;
  logic              carry_p1;

  assign grant0 = bus.req0_valid & (~prio | ~bus.req1_valid);
  assign grant1 = bus.req1_valid & ( prio | ~bus.req0_valid);
  assign accept = (state == IDLE) & (grant0 | grant1);

  assign bus.alu_a      = a_p0;
  assign bus.alu_b      = b_p0;
  assign bus.alu_op     = op_p0;
  assign bus.rsp_result = result_p1;
  assign bus.rsp_carry  = carry_p1;
  assign busy           = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (grant0 | grant1) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        bus.rsp0_valid = ~owner;
        bus.rsp1_valid = owner;
        // only the owning client's ready can release the result
        if (owner ? bus.rsp1_ready : bus.rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= PRIO_RST;
      owner     <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= '0;
      result_p1 <= '0;
      carry_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      // p0: operands registered onto the ALU inputs at accept
      if (accept) begin
        a_p0  <= grant1 ? bus.req1_a  : bus.req0_a;
        b_p0  <= grant1 ? bus.req1_b  : bus.req0_b;
        op_p0 <= grant1 ? bus.req1_op : bus.req0_op;
        owner <= grant1;
        prio  <= ~grant1;
      end
      // p1: ALU output captured at the end of EXEC
      if (state == EXEC) begin
        result_p1 <= bus.alu_result;
        carry_p1  <= bus.alu_carry;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level reference model with a
// per-cycle compare, and directed scenarios with literal expected values.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  alu_arbiter_if ifc ();

  alu_arbiter #(.PRIO_INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // External ALU: add / sub (carry = borrow) / AND / OR
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), a - b};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  assign {ifc.alu_carry, ifc.alu_result} = alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_op);

  // Reference model: one outstanding transaction, tracked by cycles since acceptance
  logic       m_busy, m_owner, m_prio;
  int         m_age;
  logic [3:0] m_a, m_b;
  logic [1:0] m_op;
  logic       e_rdy0, e_rdy1;
  logic [4:0] e_res;

  always_comb begin
    e_rdy0 = !m_busy && ifc.req0_valid && (m_prio == 1'b0 || !ifc.req1_valid);
    e_rdy1 = !m_busy && ifc.req1_valid && (m_prio == 1'b1 || !ifc.req0_valid);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_prio <= 1'b0; m_age <= 0;
      m_a <= '0; m_b <= '0; m_op <= '0;
    end else if (!m_busy) begin
      if (e_rdy0 || e_rdy1) begin
        m_owner <= e_rdy1;
        m_prio  <= !e_rdy1;
        m_a     <= e_rdy1 ? ifc.req1_a  : ifc.req0_a;
        m_b     <= e_rdy1 ? ifc.req1_b  : ifc.req0_b;
        m_op    <= e_rdy1 ? ifc.req1_op : ifc.req0_op;
        m_busy  <= 1'b1;
        m_age   <= 0;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (m_owner ? ifc.rsp1_ready : ifc.rsp0_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      e_res = alu_fn(m_a, m_b, m_op);
      chk("m_req0_ready", 32'(ifc.req0_ready), 32'(e_rdy0));
      chk("m_req1_ready", 32'(ifc.req1_ready), 32'(e_rdy1));
      chk("m_rsp0_valid", 32'(ifc.rsp0_valid), 32'(m_busy && m_age >= 1 && !m_owner));
      chk("m_rsp1_valid", 32'(ifc.rsp1_valid), 32'(m_busy && m_age >= 1 && m_owner));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_alu_a", 32'(ifc.alu_a), 32'(m_a));
      chk("m_alu_b", 32'(ifc.alu_b), 32'(m_b));
      chk("m_alu_op", 32'(ifc.alu_op), 32'(m_op));
      if (m_busy && m_age >= 1) begin
        chk("m_rsp_result", 32'(ifc.rsp_result), 32'(e_res[3:0]));
        chk("m_rsp_carry", 32'(ifc.rsp_carry), 32'(e_res[4]));
      end
    end
  end

  task automatic run_op(input bit port, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, output logic [3:0] r, output logic c);
    int n;
    if (port) begin
      ifc.req1_a = a; ifc.req1_b = b; ifc.req1_op = op; ifc.req1_valid = 1'b1;
    end else begin
      ifc.req0_a = a; ifc.req0_b = b; ifc.req0_op = op; ifc.req0_valid = 1'b1;
    end
    n = 0;
    #1;
    while (!(port ? ifc.req1_ready : ifc.req0_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("run_op_accept_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    n = 0;
    #1;
    while (!(port ? ifc.rsp1_valid : ifc.rsp0_valid) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 20) chk("run_op_rsp_timeout", 32'(n), 32'(0));
    r = ifc.rsp_result;
    c = ifc.rsp_carry;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic       c;
    logic       gown [3];
    int         gcyc [3];
    logic [3:0] gres [3];
    int         ng, nr, cyc, bad;

    rst_n = 1'b0;
    ifc.req0_valid = 0; ifc.req0_a = 0; ifc.req0_b = 0; ifc.req0_op = 0;
    ifc.req1_valid = 0; ifc.req1_a = 0; ifc.req1_b = 0; ifc.req1_op = 0;
    ifc.rsp0_ready = 0; ifc.rsp1_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp0_valid", 32'(ifc.rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(ifc.rsp1_valid), 0);
    chk("rst_alu_a", 32'(ifc.alu_a), 0);
    chk("rst_alu_b", 32'(ifc.alu_b), 0);
    chk("rst_alu_op", 32'(ifc.alu_op), 0);
    chk("rst_result", 32'(ifc.rsp_result), 0);
    chk("rst_carry", 32'(ifc.rsp_carry), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single add 0101 + 0011
    ifc.rsp0_ready = 1; ifc.rsp1_ready = 1;
    ifc.req0_a = 4'b0101; ifc.req0_b = 4'b0011; ifc.req0_op = 2'b00; ifc.req0_valid = 1;
    #1;
    chk("add_req0_ready", 32'(ifc.req0_ready), 1);
    chk("add_req1_ready", 32'(ifc.req1_ready), 0);
    @(posedge clk); #1;
    ifc.req0_valid = 0;
    #1;
    chk("add_alu_a", 32'(ifc.alu_a), 32'h5);
    chk("add_alu_b", 32'(ifc.alu_b), 32'h3);
    chk("add_alu_op", 32'(ifc.alu_op), 0);
    chk("add_busy", 32'(busy), 1);
    chk("add_rsp0_early", 32'(ifc.rsp0_valid), 0);
    @(posedge clk); #2;
    chk("add_rsp0_valid", 32'(ifc.rsp0_valid), 1);
    chk("add_result", 32'(ifc.rsp_result), 32'h8);
    chk("add_carry", 32'(ifc.rsp_carry), 0);
    chk("add_rsp1_valid", 32'(ifc.rsp1_valid), 0);
    @(posedge clk); #2;
    chk("add_idle", 32'(busy), 0);
    @(posedge clk); #1;

    // carry out on req1: 1111 + 0001
    run_op(1'b1, 4'b1111, 4'b0001, 2'b00, r, c);
    chk("carry_result", 32'(r), 0);
    chk("carry_carry", 32'(c), 1);

    // contention, priority back at 0
    ifc.req0_a = 4'b1001; ifc.req0_b = 4'b0010; ifc.req0_op = 2'b01;
    ifc.req1_a = 4'b1100; ifc.req1_b = 4'b1010; ifc.req1_op = 2'b10;
    ifc.req0_valid = 1; ifc.req1_valid = 1;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 3 && cyc < 40) begin
      #1;
      if ((ifc.req0_ready || ifc.req1_ready) && ng < 3) begin
        gown[ng] = ifc.req1_ready; gcyc[ng] = cyc; ng++;
      end
      if (ifc.rsp0_valid || ifc.rsp1_valid) begin
        gres[nr] = ifc.rsp_result; nr++;
      end
      @(posedge clk); #1;
      if (ng == 3) begin ifc.req0_valid = 0; ifc.req1_valid = 0; end
      cyc++;
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0;
    chk("cont_grants", 32'(ng), 3);
    chk("cont_responses", 32'(nr), 3);
    if (ng == 3 && nr == 3) begin
      chk("cont_owner0", 32'(gown[0]), 0);
      chk("cont_owner1", 32'(gown[1]), 1);
      chk("cont_owner2", 32'(gown[2]), 0);
      chk("cont_gap01", 32'(gcyc[1] - gcyc[0]), 3);
      chk("cont_gap12", 32'(gcyc[2] - gcyc[1]), 3);
      chk("cont_res0", 32'(gres[0]), 32'h7);
      chk("cont_res1", 32'(gres[1]), 32'h8);
      chk("cont_res2", 32'(gres[2]), 32'h7);
    end
    @(posedge clk); #1;

    // response backpressure on req0 with req1 waiting
    ifc.rsp0_ready = 0; ifc.rsp1_ready = 1;
    ifc.req0_a = 4'b0101; ifc.req0_b = 4'b0011; ifc.req0_op = 2'b00; ifc.req0_valid = 1;
    #1;
    chk("bp_req0_ready", 32'(ifc.req0_ready), 1);
    @(posedge clk); #1;
    ifc.req0_valid = 0;
    ifc.req1_a = 4'b1100; ifc.req1_b = 4'b1010; ifc.req1_op = 2'b11; ifc.req1_valid = 1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp0_valid", 32'(ifc.rsp0_valid), 1);
      chk("bp_result", 32'(ifc.rsp_result), 32'h8);
      chk("bp_req1_ready", 32'(ifc.req1_ready), 0);
      chk("bp_rsp1_valid", 32'(ifc.rsp1_valid), 0);
      @(posedge clk);
    end
    #1;
    ifc.rsp0_ready = 1;
    #1;
    chk("bp_rsp0_still", 32'(ifc.rsp0_valid), 1);
    @(posedge clk); #2;
    chk("bp_req1_ready_after", 32'(ifc.req1_ready), 1);
    @(posedge clk); #1;
    ifc.req1_valid = 0;
    @(posedge clk); #1;
    chk("bp_rsp1_valid", 32'(ifc.rsp1_valid), 1);
    chk("bp_req1_result", 32'(ifc.rsp_result), 32'hE);
    chk("bp_req1_carry", 32'(ifc.rsp_carry), 0);
    @(posedge clk); #1;

    // reset during EXEC of a req0 operation (priority is 1 afterwards if not reset)
    ifc.req0_a = 4'b0011; ifc.req0_b = 4'b0100; ifc.req0_op = 2'b00; ifc.req0_valid = 1;
    #1;
    chk("abort_req0_ready", 32'(ifc.req0_ready), 1);
    @(posedge clk); #1;
    ifc.req0_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp0_valid", 32'(ifc.rsp0_valid), 0);
    chk("abort_rsp1_valid", 32'(ifc.rsp1_valid), 0);
    chk("abort_alu_a", 32'(ifc.alu_a), 0);
    chk("abort_alu_b", 32'(ifc.alu_b), 0);
    chk("abort_result", 32'(ifc.rsp_result), 0);
    chk("abort_carry", 32'(ifc.rsp_carry), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ifc.rsp0_valid || ifc.rsp1_valid) bad++;
    end
    chk("abort_no_rsp", 32'(bad), 0);
    ifc.req0_a = 4'b0001; ifc.req0_b = 4'b0001; ifc.req0_op = 2'b00;
    ifc.req1_a = 4'b0010; ifc.req1_b = 4'b0010; ifc.req1_op = 2'b00;
    ifc.req0_valid = 1; ifc.req1_valid = 1;
    #1;
    chk("abort_prio_ready0", 32'(ifc.req0_ready), 1);
    chk("abort_prio_ready1", 32'(ifc.req1_ready), 0);
    @(posedge clk); #1;
    ifc.req0_valid = 0; ifc.req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU (`alu_4bit`). It accepts operations from two independent client ports using valid/ready handshakes and registers the operands onto the ALU inputs. It then captures the ALU's Result/Carry and returns them to the owning client, also with a valid/ready handshake. The ALU itself is instantiated outside this block; its ports connect to the `alu_*` signals below.

## Interface

Parameters
- `PRIO_INIT`, default 0: requester that holds priority after reset (0 or 1).

Ports
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  arbiter accepts the operation this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  4  operands.
- `req0_op` / `req1_op`  in  2  ALU opcode: 00 add, 01 sub, 10 AND, 11 OR.
- `rsp0_valid` / `rsp1_valid`  out  1  response available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the response.
- `rsp_result`  out  4  captured ALU Result; meaningful while either `rspX_valid` is high.
- `rsp_carry`  out  1  captured ALU Carry; same qualification as `rsp_result`.
- `alu_a`, `alu_b`  out  4  to ALU A and B.
- `alu_op`  out  2  to ALU Op.
- `alu_result`  in  4  from ALU Result.
- `alu_carry`  in  1  from ALU Carry.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- Grant logic (combinational, evaluated in IDLE only):
  - `grant0 = req0_valid & (prio==0 | ~req1_valid)`
  - `grant1 = req1_valid & (prio==1 | ~req0_valid)`
  - `reqX_ready = (state==IDLE) & grantX`. At most one ready is high in any cycle.
- IDLE, on handshake (`reqX_valid & reqX_ready`):
  - latch a, b and op into the operand registers;
  - record `owner = X`;
  - set `prio` to the other requester;
  - move to EXEC.
- IDLE with no valid: stay in IDLE; `prio` unchanged.
- `alu_a`, `alu_b` and `alu_op` are driven directly from the operand registers at all times and change only on accept.
- EXEC (exactly 1 cycle): capture `alu_result` and `alu_carry` into `rsp_result` and `rsp_carry`, then move to RESP. Opcode and result bits pass through unmodified; this block does no arithmetic.
- RESP:
  - `rsp<owner>_valid` is high; the other `rspX_valid` is low.
  - `rsp_result` and `rsp_carry` are held stable.
  - On `rsp<owner>_ready`, move to IDLE. The non-owner's `rsp_ready` is ignored.
- Requester inputs that change while not in IDLE have no effect. A requester must hold `valid` and its operands stable until it sees `ready`.
- Reset (any state, any time):
  - an in-flight operation is discarded and no response is issued;
  - state returns to IDLE and `prio = PRIO_INIT`;
  - operand registers, `rsp_result` and `rsp_carry` clear to 0;
  - all valid outputs and `busy` are low.

## Timing

- Reset values: all `ready`/`valid` outputs 0, `alu_a = alu_b = 0`, `alu_op = 00`, `rsp_result = 0`, `rsp_carry = 0`, `busy = 0`.
- Accept at edge T:
  - `busy` and the new `alu_*` values appear after T;
  - result is captured at edge T+1;
  - `rspX_valid` is high from T+1 onward.
- If `rspX_ready` is high in the cycle after T+1, the FSM is back in IDLE after edge T+2. The next accept is possible at edge T+3.
- Maximum throughput is one operation per 3 cycles.
- Ready is combinational from the other requester's valid; there is no combinational path from `rsp_ready` to any output.
- Under back-to-back contention the grants strictly alternate: 0, 1, 0, 1…

## Test plan

- Single add: after reset, req0 = (A=0101, B=0011, op 00) -> `req0_ready` in the same cycle; `alu_a/b/op` = 0101/0011/00 the next cycle; `rsp0_valid` with `rsp_result = 1000`, `carry = 0` one cycle later; `rsp1_valid` stays 0.
- Carry out: req1 = (1111, 0001, op 00) -> `rsp1_valid`, `rsp_result = 0000`, `rsp_carry = 1`.
- Contention with `PRIO_INIT = 0`: both requesters valid continuously, req0 = (1001, 0010, op 01), req1 = (1100, 1010, op 10) -> grant order 0, 1, 0; results 0111, 1000, 0111; each grant exactly 3 cycles apart with `rsp_ready` tied high.
- Response backpressure: hold `rsp0_ready = 0` for 5 cycles with req1 valid = (1100, 1010, op 11) -> `rsp0_valid` and `result = 1000` held for 5 cycles; `req1_ready` stays 0; asserting `rsp1_ready` has no effect; req1 is accepted in the cycle after `rsp0_ready`, giving result 1110.
- Reset mid-operation: assert `rst_n = 0` asynchronously during EXEC -> all outputs immediately at reset values; after release no `rsp_valid` is ever issued for the aborted operation; priority returns to `PRIO_INIT`.
